// File: rtl/weight_dma_pkg.sv
// Shared types and constants for the weight DMA scheduler: FSM states, bank
// numbering and the one-hot bank-select decode.
package weight_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NBANK = 5;

    localparam logic [2:0] BANK_CONV = 3'd0;
    localparam logic [2:0] BANK_FC0  = 3'd1;
    localparam logic [2:0] BANK_FC1  = 3'd2;
    localparam logic [2:0] BANK_FC2  = 3'd3;
    localparam logic [2:0] BANK_FC3  = 3'd4;

    function automatic logic [NBANK-1:0] bank_onehot(input logic [2:0] idx);
        logic [NBANK-1:0] sel;
        sel = '0;
        if (idx <= BANK_FC3) sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/weight_dma_sched.sv
// Sequencing DMA from ITCM into the conv bank and four FC weight banks.
// Optional running checksum of written words is built when WDMA_CHECKSUM_EN is defined.
module weight_dma_sched
    import weight_dma_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [AW-1:0]    i_conv_len,
    input  logic [AW-1:0]    i_fc_len,
    output logic [AW-1:0]    o_itcm_addr,
    input  logic [DW-1:0]    i_itcm_data,
    output logic [NBANK-1:0] o_bank_sel,
    output logic             o_wr_en,
    output logic [AW-1:0]    o_wr_addr,
    output logic [DW-1:0]    o_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_checksum
);

    // Total word count needs headroom for conv_len + 4*fc_len
    localparam int TW = AW + 3;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   conv_len;
    logic [AW-1:0]   fc_len;
    logic [2:0]      bank;
    logic [AW-1:0]   cnt;
    logic [TW-1:0]   remain;
    logic [TW-1:0]   total_in;
    logic [AW-1:0]   bank_len;
    logic            last_in_bank;
    logic            start_acc;
    logic            running;

    assign total_in     = {3'b000, i_conv_len} + {1'b0, i_fc_len, 2'b00};
    assign start_acc    = (state_q == IDLE) && i_start && !i_abort;
    assign running      = (state_q == RUN) && !i_abort;
    assign bank_len     = (bank == BANK_CONV) ? conv_len : fc_len;
    assign last_in_bank = (cnt == bank_len - AW'(1));
    assign o_busy       = (state_q == RUN) || (state_q == DRAIN);
    assign o_wr_data    = i_itcm_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (i_start) state_d = (total_in == '0) ? DONE : RUN;
                RUN:     if (remain == '0) state_d = DRAIN;
                DRAIN:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (start_acc) begin
            conv_len <= i_conv_len;
            fc_len   <= i_fc_len;
        end
    end

    // Read side: address, bank position and remaining-word count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_itcm_addr <= '0;
            bank        <= BANK_CONV;
            cnt         <= '0;
            remain      <= '0;
        end else if (start_acc) begin
            o_itcm_addr <= '0;
            bank        <= (i_conv_len == '0) ? BANK_FC0 : BANK_CONV;
            cnt         <= '0;
            remain      <= total_in - TW'(1);
        end else if (running) begin
            if (remain != '0) begin
                o_itcm_addr <= o_itcm_addr + AW'(1);
                remain      <= remain - TW'(1);
            end
            // Only conv can be empty, so once past it the next bank is always bank+1
            if (last_in_bank) begin
                bank <= bank + 3'd1;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + AW'(1);
            end
        end
    end

    // Write side: one cycle behind the read address, aligned with ITCM data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_en    <= 1'b0;
            o_bank_sel <= '0;
            o_wr_addr  <= '0;
            o_done     <= 1'b0;
        end else begin
            o_wr_en    <= running;
            o_bank_sel <= running ? bank_onehot(bank) : '0;
            if (running) o_wr_addr <= cnt;
            // Zero-length jobs enter DONE straight from IDLE, so the pulse fires on leaving it
            o_done     <= !i_abort &&
                          ((state_q == DRAIN) || ((state_q == DONE) && !o_done));
        end
    end

`ifdef WDMA_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          csum <= '0;
        else if (start_acc) csum <= '0;
        else if (o_wr_en)   csum <= csum + 16'(o_wr_data);
    end

    assign o_checksum = csum;
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_weight_dma_sched.sv
// Scoreboard bench for weight_dma_sched: the model lists expected writes per
// transfer, a negedge monitor pops and compares every write the DUT makes.
module tb_weight_dma_sched;

    localparam int DW = 16;
    localparam int AW = 16;

    typedef struct {
        logic [4:0]  sel;
        logic [15:0] waddr;
        logic [15:0] data;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [AW-1:0] i_conv_len = '0;
    logic [AW-1:0] i_fc_len = '0;
    logic [AW-1:0] o_itcm_addr;
    logic [DW-1:0] i_itcm_data = '0;
    logic [4:0]    o_bank_sel;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_busy;
    logic          o_done;
    logic [15:0]   o_checksum;

    int   checks = 0;
    int   fails = 0;
    exp_t expq[$];
    exp_t mon_e;
    logic [15:0] mul = 16'd1;
    logic [15:0] off = 16'd0;

    weight_dma_sched #(.DW(DW), .AW(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_conv_len(i_conv_len), .i_fc_len(i_fc_len),
        .o_itcm_addr(o_itcm_addr), .i_itcm_data(i_itcm_data),
        .o_bank_sel(o_bank_sel), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done),
        .o_checksum(o_checksum)
    );

    always #5 i_clk = ~i_clk;

    // ITCM model: word at address a is mul*a+off, returned one cycle after the address
    always @(posedge i_clk) i_itcm_data <= mul * o_itcm_addr + off;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_wr_en) begin
                if (expq.size() == 0) begin
                    check("unexpected_write", {31'd0, o_wr_en}, 32'd0);
                end else begin
                    mon_e = expq.pop_front();
                    check("wr_bank_sel", {27'd0, o_bank_sel}, {27'd0, mon_e.sel});
                    check("wr_addr", {16'd0, o_wr_addr}, {16'd0, mon_e.waddr});
                    check("wr_data", {16'd0, o_wr_data}, {16'd0, mon_e.data});
                end
            end else begin
                check("bank_sel_idle", {27'd0, o_bank_sel}, 32'd0);
            end
        end
    end

    // abort_at = A: abort is sampled at edge E_A, so writes land only at E1..E_{A-1}
    task automatic run_xfer(input int conv, input int fc, input int ign_at,
                            input int abort_at, input bit ident);
        int total, nwr, a, n, bound;
        bit seen;
        logic [15:0] sum;
        exp_t e;
        total = conv + 4 * fc;
        if (ident) begin
            mul = 16'd1;
            off = 16'd0;
        end else begin
            mul = 16'($urandom) | 16'h0001;
            off = 16'($urandom);
        end
        nwr = (abort_at > 0 && abort_at - 1 < total) ? abort_at - 1 : total;
        a = 0;
        sum = '0;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < ((b == 0) ? conv : fc); k++) begin
                if (a < nwr) begin
                    e.sel   = 5'(1 << b);
                    e.waddr = 16'(k);
                    e.data  = 16'(mul * a + off);
                    sum     = sum + e.data;
                    expq.push_back(e);
                end
                a++;
            end
        end

        i_start    = 1'b1;
        i_conv_len = 16'(conv);
        i_fc_len   = 16'(fc);
        @(posedge i_clk);
        #1;
        i_start    = 1'b0;
        i_conv_len = 16'($urandom);
        i_fc_len   = 16'($urandom);
        check("first_itcm_addr", {16'd0, o_itcm_addr}, 32'd0);

        bound = (abort_at > 0) ? abort_at + 10 : total + 10;
        seen = 1'b0;
        for (n = 1; n <= bound; n++) begin
            if (n == ign_at) i_start = 1'b1;
            if (n == abort_at) i_abort = 1'b1;
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            i_abort = 1'b0;
            if (abort_at > 0 && n == abort_at) begin
                check("abort_wr_en", {31'd0, o_wr_en}, 32'd0);
                check("abort_busy", {31'd0, o_busy}, 32'd0);
            end
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end

        if (abort_at > 0) begin
            check("abort_no_done", {31'd0, o_done}, 32'd0);
        end else if (!seen) begin
            check("done_timeout", {31'd0, o_done}, 32'd1);
        end else begin
            check("done_cycle", n, total + 1);
            check("busy_at_done", {31'd0, o_busy}, 32'd0);
            @(posedge i_clk);
            #1;
            check("done_pulse_width", {31'd0, o_done}, 32'd0);
`ifdef WDMA_CHECKSUM_EN
            check("checksum", {16'd0, o_checksum}, {16'd0, sum});
`else
            check("checksum", {16'd0, o_checksum}, 32'd0);
`endif
        end
        repeat (2) @(posedge i_clk);
        #1;
        check("queue_drained", expq.size(), 32'd0);
        expq.delete();
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("rst_itcm_addr", {16'd0, o_itcm_addr}, 32'd0);
        check("rst_bank_sel", {27'd0, o_bank_sel}, 32'd0);
        check("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        check("rst_wr_addr", {16'd0, o_wr_addr}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_checksum", {16'd0, o_checksum}, 32'd0);

        run_xfer(162, 1296, 0, 0, 1'b0);
        run_xfer(2, 1, 0, 0, 1'b1);
        run_xfer(0, 3, 0, 0, 1'b0);
        run_xfer(0, 0, 0, 0, 1'b0);
        run_xfer(162, 1296, 100, 0, 1'b0);
        run_xfer(162, 1296, 0, 51, 1'b0);
        run_xfer(2, 1, 0, 0, 1'b0);

        // Start and abort together in IDLE: nothing may begin
        i_start    = 1'b1;
        i_abort    = 1'b1;
        i_conv_len = 16'd4;
        i_fc_len   = 16'd2;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        check("abort_start_busy", {31'd0, o_busy}, 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        check("abort_start_done", {31'd0, o_done}, 32'd0);
        check("abort_start_wr_en", {31'd0, o_wr_en}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            run_xfer(int'($urandom_range(0, 20)), int'($urandom_range(0, 12)), 0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/weight_dma_sched.md
# weight_dma_sched

Sequencing DMA controller that moves weights from the core-side ITCM into the accelerator's five weight SRAM banks: one conv bank and four FC banks. It replaces ad-hoc load control with a single start/done handshake. Bank-select, write-enable and write-address are generated cycle-accurately so the SRAM instances hang directly off its outputs. It sits between the ITCM read port and the conv/FC SRAM write ports; the CNN pipeline is released by its done pulse.

## Interface
- DW, 16, data width of ITCM words and SRAM words
- AW, 16, width of all addresses, lengths and counters
- i_clk  in  1  single clock for all logic
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- i_abort  in  1  cancel transfer; highest priority after reset
- i_conv_len  in  AW  conv word count; latched on accepted start
- i_fc_len  in  AW  per-FC-bank word count; latched on accepted start
- o_itcm_addr  out  AW  ITCM read address, registered
- i_itcm_data  in  DW  ITCM read data, valid one cycle after address
- o_bank_sel  out  5  one-hot write bank: bit0 conv, bits1..4 fc0..fc3
- o_wr_en  out  1  SRAM write strobe
- o_wr_addr  out  AW  address inside selected bank
- o_wr_data  out  DW  equals i_itcm_data (pass-through)
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  one-cycle completion pulse
- o_checksum  out  16  running sum of written words (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: i_start=1 latches both lengths, clears counters, goes to RUN. Start outside IDLE is ignored.
- ITCM layout: conv words at 0..conv_len-1. FC bank j occupies conv_len + j*fc_len .. conv_len + (j+1)*fc_len - 1.
- RUN: each cycle issues one ITCM address, incrementing by 1.
  - A bank index (0..4) and an in-bank word counter track position. When the counter reaches bank length-1, the bank index advances and the counter clears.
  - Banks with length 0 are skipped with no bubble.
- Write side: bank index and word counter are delayed one cycle to form o_bank_sel and o_wr_addr, aligned with i_itcm_data.
- After the last address, RUN goes to DRAIN (final write), then DONE (o_done=1), then IDLE.
- Total T = conv_len + 4*fc_len. If T=0, IDLE goes straight to DONE with no writes.
- Address arithmetic wraps modulo 2^AW; no overflow flag.
- i_abort in RUN/DRAIN/DONE: next state IDLE. o_wr_en drops the next cycle, o_done is not pulsed, and already-written data is left in place.
- Reset values: state IDLE, o_itcm_addr 0, o_bank_sel 0, o_wr_en 0, o_wr_addr 0, o_busy 0, o_done 0, o_checksum 0.

## Timing
- Start sampled at edge E0: o_itcm_addr=0 in cycle E0–E1. First write (bank conv, addr 0) in cycle E1–E2.
- Throughput: one word per cycle, no stalls.
- Bank switch: the last conv write (addr conv_len-1) is immediately followed by fc0 addr 0.
- Last write in cycle E_T–E_{T+1} (DRAIN). o_done is high in cycle E_{T+1}–E_{T+2}. o_busy falls at E_{T+1}.
- o_bank_sel is non-zero only while o_wr_en=1.
- i_start and i_abort in the same IDLE cycle: abort wins and the start is ignored.

## Configuration
- WDMA_CHECKSUM_EN defined:
  - o_checksum clears on accepted start.
  - It adds o_wr_data mod 2^16 on every cycle with o_wr_en=1.
  - It holds its value after done.
- WDMA_CHECKSUM_EN undefined: o_checksum is tied to 0 and the adder is not built.

## Structure
- Package weight_dma_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - NBANK=5
  - bank index constants BANK_CONV=0, BANK_FC0..BANK_FC3=1..4
  - one-hot decode function for o_bank_sel
- Single module; no sub-module. Counters, write-side delay registers and the optional checksum are all local.

## Test plan
- Default lengths conv=162, fc=1296: 5346 writes. Conv addr 0..161, then each FC bank 0..1295. o_itcm_addr runs 0..5345 contiguous. o_done at E5347.
- conv=2, fc=1: bank order conv,conv,fc0,fc1,fc2,fc3 with wr_addr 0,1,0,0,0,0; ITCM words 0..5 land in that order; done at E7.
- conv=0, fc=3: first write is fc0 addr 0 at E1 with no conv write. Both lengths 0: o_done at E1, o_wr_en never asserted.
- i_start pulsed at E100 during a default transfer: ignored; write sequence and done time unchanged.
- i_abort at E50 of a default transfer: o_wr_en low from E51, no o_done, o_busy low from E51. A new start at E60 restarts from ITCM addr 0.
- With WDMA_CHECKSUM_EN and ITCM word k = k, conv=2, fc=1: o_checksum=15 after done. Without the macro: 0.
